// File: rtl/word_serializer.sv
// Parallel-to-serial word converter, LSB first, with first/last bit flags.
// Back-to-back words stream with no bubble when din_valid is held.
module word_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             t_clk,
   input  logic             r,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sfirst,
   output logic             slast,
   output logic             sval
);

   localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic ONE_BIT = (WIDTH == 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_inc;
   logic             on_last;
   logic             accept;

   assign cnt_inc   = cnt + ONE;
   assign on_last   = (state == SHIFT) && (cnt == LAST);
   assign din_ready = (state == IDLE) || on_last;
   assign accept    = din_valid && din_ready;
   assign sout      = sreg[0];

   // Acceptance is checked before the last-bit return to IDLE so a
   // waiting word follows the previous MSB with no idle cycle.
   always_ff @(posedge t_clk) begin
      if (r) begin
         state  <= IDLE;
         sreg   <= '0;
         cnt    <= '0;
         sval   <= 1'b0;
         sfirst <= 1'b0;
         slast  <= 1'b0;
      end else if (accept) begin
         state  <= SHIFT;
         sreg   <= din;
         cnt    <= '0;
         sval   <= 1'b1;
         sfirst <= 1'b1;
         slast  <= ONE_BIT;
      end else if (on_last) begin
         state  <= IDLE;
         sreg   <= '0;
         cnt    <= '0;
         sval   <= 1'b0;
         sfirst <= 1'b0;
         slast  <= 1'b0;
      end else if (state == SHIFT) begin
         sreg   <= sreg >> 1;
         cnt    <= cnt_inc;
         sval   <= 1'b1;
         sfirst <= 1'b0;
         slast  <= (cnt_inc == LAST);
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: WIDTH=8 and WIDTH=1 instances.
// Expected bits go to a scoreboard when words are driven.
module tb_word_serializer;

   typedef struct packed {
      logic b;
      logic f;
      logic l;
   } bit_t;

   typedef struct {
      logic [7:0] word;
      logic [7:0] exp_bits;
      bit         noise;
   } vec_t;

   logic       t_clk = 1'b0;
   logic       r = 1'b1;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic       sout, sfirst, slast, sval;

   logic       din1 = 1'b0;
   logic       din_valid1 = 1'b0;
   logic       din_ready1;
   logic       sout1, sfirst1, slast1, sval1;

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;
   bit_t q8[$];
   bit_t q1[$];
   bit_t e8, e1;

   always #5 t_clk = ~t_clk;

   word_serializer #(.WIDTH(8)) dut8 (
      .t_clk     (t_clk),
      .r         (r),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .sout      (sout),
      .sfirst    (sfirst),
      .slast     (slast),
      .sval      (sval)
   );

   word_serializer #(.WIDTH(1)) dut1 (
      .t_clk     (t_clk),
      .r         (r),
      .din       (din1),
      .din_valid (din_valid1),
      .din_ready (din_ready1),
      .sout      (sout1),
      .sfirst    (sfirst1),
      .slast     (slast1),
      .sval      (sval1)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge t_clk);
      #1;
   endtask

   task automatic push8(logic [7:0] w);
      bit_t e;
      for (int k = 0; k < 8; k++) begin
         e.b = w[k];
         e.f = (k == 0);
         e.l = (k == 7);
         q8.push_back(e);
      end
   endtask

   task automatic push1(logic b);
      bit_t e;
      e.b = b;
      e.f = 1'b1;
      e.l = 1'b1;
      q1.push_back(e);
   endtask

   always @(negedge t_clk) begin
      if (mon_en) begin
         if (sval) begin
            if (q8.size() == 0) begin
               chk("sb8_extra_bit", 1, 0);
            end else begin
               e8 = q8.pop_front();
               chk("sb8_sout", sout, e8.b);
               chk("sb8_sfirst", sfirst, e8.f);
               chk("sb8_slast", slast, e8.l);
            end
         end else begin
            chk("sb8_idle_outs", {sout, sfirst, slast}, 0);
         end
         if (sval1) begin
            if (q1.size() == 0) begin
               chk("sb1_extra_bit", 1, 0);
            end else begin
               e1 = q1.pop_front();
               chk("sb1_sout", sout1, e1.b);
               chk("sb1_sfirst", sfirst1, e1.f);
               chk("sb1_slast", slast1, e1.l);
            end
         end else begin
            chk("sb1_idle_outs", {sout1, sfirst1, slast1}, 0);
         end
      end
   end

   task automatic play(logic [7:0] w, logic [7:0] exp, bit noise);
      din = w;
      din_valid = 1'b1;
      push8(exp);
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk("tbl_sval", sval, 1);
         chk("tbl_ready", din_ready, (c == 8));
         if (noise && c < 8)
            din = (c < 4) ? 8'hFF : 8'h00;
         else
            din_valid = 1'b0;
      end
      tick();
      chk("tbl_idle_sval", sval, 0);
      chk("tbl_idle_ready", din_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[6];
      logic [7:0] res;
      logic       seen;

      tbl[0] = '{word: 8'h0C, exp_bits: 8'b0000_1100, noise: 1'b0};
      tbl[1] = '{word: 8'hA5, exp_bits: 8'b1010_0101, noise: 1'b1};
      tbl[2] = '{word: 8'hFF, exp_bits: 8'b1111_1111, noise: 1'b0};
      tbl[3] = '{word: 8'h00, exp_bits: 8'b0000_0000, noise: 1'b1};
      tbl[4] = '{word: 8'h5A, exp_bits: 8'b0101_1010, noise: 1'b1};
      tbl[5] = '{word: 8'h80, exp_bits: 8'b1000_0000, noise: 1'b0};

      // reset with a word pending: reset must win
      din = 8'h3C;
      din_valid = 1'b1;
      tick();
      tick();
      chk("rst_sval", sval, 0);
      chk("rst_outs", {sout, sfirst, slast}, 0);
      chk("rst_ready", din_ready, 1);
      chk("rst_sval1", sval1, 0);
      chk("rst_ready1", din_ready1, 1);
      mon_en = 1'b1;
      r = 1'b0;
      push8(8'h3C);
      tick();
      chk("first_edge_accept", sval, 1);
      chk("first_edge_sfirst", sfirst, 1);
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("first_word_done", sval, 0);

      for (int i = 0; i < 6; i++)
         play(tbl[i].word, tbl[i].exp_bits, tbl[i].noise);

      // back-to-back 0x01 then 0x80
      din = 8'h01;
      din_valid = 1'b1;
      push8(8'h01);
      for (int c = 1; c <= 16; c++) begin
         tick();
         chk("b2b_sval", sval, 1);
         chk("b2b_ready", din_ready, (c == 8 || c == 16));
         chk("b2b_sfirst", sfirst, (c == 1 || c == 9));
         if (c == 1) begin
            din = 8'h80;
            push8(8'h80);
         end
         if (c == 9) din_valid = 1'b0;
      end
      tick();
      chk("b2b_end_sval", sval, 0);

      // reset during cycle 4 of 0xFF
      din = 8'hFF;
      din_valid = 1'b1;
      push8(8'hFF);
      tick();
      din_valid = 1'b0;
      tick();
      tick();
      tick();
      r = 1'b1;
      tick();
      chk("midrst_sval", sval, 0);
      chk("midrst_slast", slast, 0);
      chk("midrst_ready", din_ready, 1);
      q8.delete();
      q1.delete();
      r = 1'b0;
      din = 8'h02;
      din_valid = 1'b1;
      push8(8'h02);
      tick();
      chk("midrst_new_sfirst", sfirst, 1);
      chk("midrst_new_bit0", sout, 0);
      din_valid = 1'b0;
      tick();
      chk("midrst_new_bit1", sout, 1);
      for (int i = 0; i < 7; i++) tick();
      chk("midrst_new_done", sval, 0);

      // WIDTH=1: words 1,0,1 back-to-back
      din1 = 1'b1;
      din_valid1 = 1'b1;
      push1(1'b1);
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("w1_sval", sval1, 1);
         chk("w1_ready", din_ready1, 1);
         chk("w1_sout", sout1, (c != 2));
         if (c < 3) begin
            din1 = (c == 2);
            push1(c == 2);
         end else begin
            din_valid1 = 1'b0;
         end
      end
      tick();
      chk("w1_end_sval", sval1, 0);
      chk("w1_end_ready", din_ready1, 1);

      // end-to-end through a serial two's-complement model
      din = 8'h0C;
      din_valid = 1'b1;
      push8(8'h0C);
      res = '0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 0) din_valid = 1'b0;
         chk("e2e_sval", sval, 1);
         if (sfirst) seen = 1'b0;
         res[k] = sout ^ seen;
         seen = seen | sout;
      end
      chk("e2e_twos", res, 8'hF4);
      tick();
      tick();

      chk("sb8_drain", q8.size(), 0);
      chk("sb1_drain", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits; legal range 1..32.
REQ-002 SHALL have port t_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port r  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port din_valid  input  1  din holds a word to accept.
REQ-006 SHALL have port din_ready  output  1  block accepts din on this edge when din_valid high.
REQ-007 SHALL have port sout  output  1  serial data bit, LSB first; feeds the downstream serial two's-complement stage input.
REQ-008 SHALL have port sfirst  output  1  high for the first (LSB) bit of each word; drives the downstream stage's word-start/clear input.
REQ-009 SHALL have port slast  output  1  high for the last (MSB) bit of each word.
REQ-010 SHALL have port sval  output  1  sout carries a valid bit this cycle.

Function
REQ-011 SHALL implement two states: IDLE (no word in flight) and SHIFT (word in flight).
REQ-012 SHALL hold a WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH+1)) bits, minimum 1 bit.
REQ-013 SHALL drive din_ready combinationally: 1 in IDLE; 1 in SHIFT only while the counter equals WIDTH-1 (last bit on sout); 0 otherwise.
REQ-014 SHALL accept a word on a rising edge with din_valid=1 and din_ready=1: load din into the shift register, set counter to 0, enter or remain in SHIFT.
REQ-015 SHALL present all outputs registered: sout = shift register bit 0; sval = 1 in SHIFT, 0 in IDLE.
REQ-016 SHALL, in SHIFT without acceptance, shift the register right by one bit (zero fill) and increment the counter on each edge.
REQ-017 SHALL present bit k of an accepted word on sout in the k+1-th cycle after the accepting edge (latency 1 cycle to LSB; WIDTH cycles per word).
REQ-018 SHALL assert sfirst exactly when sval=1 and counter=0; sfirst and slast SHALL both be high when WIDTH=1.
REQ-019 SHALL assert slast exactly when sval=1 and counter=WIDTH-1.
REQ-020 SHALL, at the edge ending the last bit: load the next word with no bubble if din_valid=1 (acceptance takes priority over the return to IDLE); otherwise return to IDLE.
REQ-021 SHALL ignore din and din_valid while din_ready=0; a held din_valid SHALL NOT corrupt the word in flight.
REQ-022 SHALL drive sout=0, sfirst=0, slast=0 whenever sval=0.
REQ-023 SHALL never emit a partial word except when truncated by reset (REQ-025).

Reset
REQ-024 SHALL, on any edge with r=1, enter IDLE, clear shift register and counter; next cycle sval=0, sout=0, sfirst=0, slast=0, din_ready=1.
REQ-025 SHALL give r priority over acceptance and shifting; reset mid-word SHALL discard remaining bits, with no slast for that word.
REQ-026 SHALL accept a word on the first edge with r=0 if din_valid=1.

Verification (WIDTH=8)
REQ-027 SHALL cover single word: accept 0x0C -> cycles 1..8 sout=0,0,1,1,0,0,0,0; sfirst at cycle 1, slast at cycle 8, sval=1 for cycles 1..8 only, IDLE after.
REQ-028 SHALL cover back-to-back: 0x01 then 0x80 with din_valid held high -> 16 contiguous sval cycles, sout=1,0×7,0×7,1; sfirst at cycles 1 and 9; din_ready high only at cycles 8 and 16 (and in IDLE).
REQ-029 SHALL cover held din_valid: din changed 0xFF->0x00 during cycles 2..7 of word 0xA5 -> sout=1,0,1,0,0,1,0,1 unchanged.
REQ-030 SHALL cover reset mid-word: r=1 at cycle 4 of 0xFF -> sval=0 next cycle, no slast, din_ready=1; a new word 0x02 accepted afterwards serializes 0,1,0×6 with sfirst at its first bit.
REQ-031 SHALL cover WIDTH=1 build: words 1,0,1 back-to-back -> sout=1,0,1 with sfirst=slast=1 every cycle, din_ready constantly 1.
REQ-032 SHALL cover end-to-end: serializer driving the serial two's-complement stage with 0x0C -> collected result 0xF4.
